// File: rtl/gs_filter_pkg.sv
// Shared types and constants for the streaming binomial (Gaussian) filter.
package gs_filter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int BINOM_K3 [3] = '{1, 2, 1};
   localparam int BINOM_K5 [5] = '{1, 4, 6, 4, 1};

   // log2 of the 2-D kernel weight total
   function automatic int shift_of_k(input int k);
      return (k == 3) ? 4 : 8;
   endfunction

   function automatic int binom(input int k, input logic [2:0] i);
      if (k == 3) return BINOM_K3[i[1:0]];
      return BINOM_K5[i];
   endfunction

   function automatic int col_w(input int dw, input int k);
      return dw + shift_of_k(k) / 2;
   endfunction

   function automatic int tot_w(input int dw, input int k);
      return dw + shift_of_k(k);
   endfunction

endpackage

// File: rtl/gs_line_buf.sv
// One line of pixel storage: registered read port, independent write port, old data on collision.
module gs_line_buf #(
   parameter int DW    = 8,
   parameter int MAX_W = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata
);

   logic [DW-1:0] mem [MAX_W];

   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
      if (we) mem[waddr] <= wdata;
   end

endmodule

// File: rtl/gs_filter_stream.sv
// Streaming separable binomial filter (K=3 or 5) with valid-region output and a bypass mode.
module gs_filter_stream
   import gs_filter_pkg::*;
#(
   parameter int DW    = 8,
   parameter int MAX_W = 256,
   parameter int K     = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [15:0]   cfg_width,
   input  logic [15:0]   cfg_height,
   input  logic          cfg_bypass,
   input  logic          s_valid,
   input  logic [DW-1:0] s_data,
   output logic          s_ready,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   output logic          m_last,
   input  logic          m_ready,
   output logic          busy,
   output logic          done,
   output logic          cfg_err
);

   localparam int S     = shift_of_k(K);
   localparam int COL_W = col_w(DW, K);
   localparam int TOT_W = tot_w(DW, K);
   localparam int AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam logic [15:0] KM1    = 16'(K - 1);
   localparam logic [15:0] K16    = 16'(K);
   localparam logic [15:0] MAXW16 = 16'(MAX_W);

   if (K != 3 && K != 5) begin : g_bad_k
      $error("gs_filter_stream: K must be 3 or 5");
   end

   state_t           state, state_nx;
   logic [15:0]      width_r, height_r, x, y;
   logic             bypass_r, cfg_legal, en, accept, last_px;
   logic             acc_p0, vld_p0, last_p0, vld_p1, last_p1, vld_p2, last_p2, vld_p3, last_p3;
   logic [DW-1:0]    pix_p0, pix_p1, pix_p2, data_p3;
   logic [AW-1:0]    addr_p0;
   logic [DW-1:0]    rd_p0 [K-1];
   logic [DW-1:0]    taps [K];
   logic [COL_W-1:0] col_sum;
   logic [COL_W-1:0] col_p1 [K];
   logic [TOT_W-1:0] row_sum, row_p2;

   function automatic logic [DW-1:0] round_sum(input logic [TOT_W-1:0] sum);
      return DW'((sum + TOT_W'(1 << (S - 1))) >> S);
   endfunction

   assign en      = !vld_p3 || m_ready;
   assign accept  = s_valid && s_ready;
   assign last_px = (x == width_r - 16'd1) && (y == height_r - 16'd1);
   assign m_valid = vld_p3;
   assign m_data  = data_p3;
   assign m_last  = last_p3;

   always_comb begin
      if (cfg_bypass) cfg_legal = (cfg_width != 16'd0) && (cfg_height != 16'd0);
      else            cfg_legal = (cfg_width >= K16) && (cfg_width <= MAXW16) && (cfg_height >= K16);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start && cfg_legal) state_nx = ST_RUN;
         ST_RUN:   if (accept && last_px) state_nx = ST_DRAIN;
         ST_DRAIN: if (m_valid && m_ready && m_last) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready = (state == ST_RUN) && en;
      busy    = (state != ST_IDLE);
      done    = (state == ST_DRAIN) && m_valid && m_ready && m_last;
      cfg_err = (state == ST_IDLE) && start && !cfg_legal;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         width_r  <= '0;
         height_r <= '0;
         bypass_r <= 1'b0;
         x        <= '0;
         y        <= '0;
      end else if (state == ST_IDLE && start && cfg_legal) begin
         width_r  <= cfg_width;
         height_r <= cfg_height;
         bypass_r <= cfg_bypass;
         x        <= '0;
         y        <= '0;
      end else if (accept) begin
         if (x == width_r - 16'd1) begin
            x <= '0;
            y <= y + 16'd1;
         end else begin
            x <= x + 16'd1;
         end
      end
   end

   // Buffer g holds row y-1-g; each pixel's column is pushed down the chain one enabled cycle late.
   for (genvar g = 0; g < K - 1; g++) begin : g_lb
      gs_line_buf #(.DW(DW), .MAX_W(MAX_W), .AW(AW)) u_lb (
         .clk   (clk),
         .re    (en),
         .raddr (x[AW-1:0]),
         .rdata (rd_p0[g]),
         .we    (en && acc_p0),
         .waddr (addr_p0),
         .wdata (taps[g])
      );
   end

   always_comb begin
      taps[0] = pix_p0;
      for (int i = 1; i < K; i++) taps[i] = rd_p0[i-1];
   end

   always_comb begin
      col_sum = '0;
      for (int i = 0; i < K; i++)
         col_sum = col_sum + COL_W'(binom(K, 3'(i))) * COL_W'(taps[i]);
   end

   always_comb begin
      row_sum = '0;
      for (int i = 0; i < K; i++)
         row_sum = row_sum + TOT_W'(binom(K, 3'(i))) * TOT_W'(col_p1[i]);
   end

   // Stage 0: input pixel and line-buffer reads; valid only inside the filter's valid region
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p0  <= 1'b0;
         vld_p0  <= 1'b0;
         last_p0 <= 1'b0;
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         vld_p2  <= 1'b0;
         last_p2 <= 1'b0;
         vld_p3  <= 1'b0;
         last_p3 <= 1'b0;
      end else if (en) begin
         acc_p0  <= accept;
         vld_p0  <= accept && (bypass_r || (x >= KM1 && y >= KM1));
         last_p0 <= accept && last_px;
         vld_p1  <= vld_p0;
         last_p1 <= last_p0;
         vld_p2  <= vld_p1;
         last_p2 <= last_p1;
         vld_p3  <= vld_p2;
         last_p3 <= last_p2;
      end
   end

   // Stage 1: column sum into horizontal shift register; stage 2: row sum
   always_ff @(posedge clk) begin
      if (en) begin
         pix_p0  <= s_data;
         addr_p0 <= x[AW-1:0];
         if (acc_p0) begin
            col_p1[0] <= col_sum;
            for (int i = 1; i < K; i++) col_p1[i] <= col_p1[i-1];
         end
         pix_p1 <= pix_p0;
         pix_p2 <= pix_p1;
         row_p2 <= row_sum;
      end
   end

   // Stage 3: rounded (or bypassed) output
   always_ff @(posedge clk) begin
      if (rst)     data_p3 <= '0;
      else if (en) data_p3 <= bypass_r ? pix_p2 : round_sum(row_p2);
   end

endmodule

// File: tb/tb_gs_filter_stream.sv
// Randomised bench for gs_filter_stream (K=3 and K=5 instances) against a 2-D convolution model.
module tb_gs_filter_stream;

   logic        clk = 1'b0;
   logic        rst, start, cfg_bypass, s_valid, m_ready, sel;
   logic [15:0] cfg_width, cfg_height;
   logic [7:0]  s_data;

   logic       s_ready3, m_valid3, m_last3, busy3, done3, cfg_err3;
   logic       s_ready5, m_valid5, m_last5, busy5, done5, cfg_err5;
   logic [7:0] m_data3, m_data5;
   logic       s_ready, m_valid, m_last, busy, done, cfg_err;
   logic [7:0] m_data;

   int n_checks = 0;
   int n_errors = 0;
   int pix [4096];
   int exp_q [$];

   always #5 clk = ~clk;

   gs_filter_stream #(.DW(8), .MAX_W(256), .K(3)) dut3 (
      .clk(clk), .rst(rst), .start(start && !sel),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_bypass(cfg_bypass),
      .s_valid(s_valid && !sel), .s_data(s_data), .s_ready(s_ready3),
      .m_valid(m_valid3), .m_data(m_data3), .m_last(m_last3), .m_ready(sel ? 1'b1 : m_ready),
      .busy(busy3), .done(done3), .cfg_err(cfg_err3));

   gs_filter_stream #(.DW(8), .MAX_W(256), .K(5)) dut5 (
      .clk(clk), .rst(rst), .start(start && sel),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_bypass(cfg_bypass),
      .s_valid(s_valid && sel), .s_data(s_data), .s_ready(s_ready5),
      .m_valid(m_valid5), .m_data(m_data5), .m_last(m_last5), .m_ready(sel ? m_ready : 1'b1),
      .busy(busy5), .done(done5), .cfg_err(cfg_err5));

   assign s_ready = sel ? s_ready5 : s_ready3;
   assign m_valid = sel ? m_valid5 : m_valid3;
   assign m_data  = sel ? m_data5  : m_data3;
   assign m_last  = sel ? m_last5  : m_last3;
   assign busy    = sel ? busy5    : busy3;
   assign done    = sel ? done5    : done3;
   assign cfg_err = sel ? cfg_err5 : cfg_err3;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   function automatic int binom_ref(input int k, input int i);
      int c = 1;
      for (int j = 0; j < i; j++) c = c * (k - 1 - j) / (j + 1);
      return c;
   endfunction

   task automatic build_exp(input int k, input int w, input int h, input bit byp);
      exp_q.delete();
      if (byp) begin
         for (int i = 0; i < w * h; i++) exp_q.push_back(pix[i]);
      end else begin
         int s = 2 * (k - 1);
         for (int j = 0; j <= h - k; j++)
            for (int i = 0; i <= w - k; i++) begin
               int acc = 0;
               for (int dy = 0; dy < k; dy++)
                  for (int dx = 0; dx < k; dx++)
                     acc += binom_ref(k, dy) * binom_ref(k, dx) * pix[(j + dy) * w + i + dx];
               exp_q.push_back((acc + (1 << (s - 1))) >> s);
            end
      end
   endtask

   // mode 0: constant, 1: single 255 at (3,3), 2: random, 3: ramp from 1
   task automatic fill_pix(input int mode, input int w, input int h, input int val);
      for (int i = 0; i < w * h; i++)
         case (mode)
            0:       pix[i] = val;
            1:       pix[i] = (i == 3 * w + 3) ? 255 : 0;
            2:       pix[i] = int'($urandom_range(0, 255));
            default: pix[i] = i + 1;
         endcase
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_s_ready"}, 32'(s_ready), 0);
      chk({tag, "_m_valid"}, 32'(m_valid), 0);
      chk({tag, "_m_data"},  32'(m_data),  0);
      chk({tag, "_m_last"},  32'(m_last),  0);
      chk({tag, "_busy"},    32'(busy),    0);
      chk({tag, "_done"},    32'(done),    0);
      chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
   endtask

   task automatic cfg_reject(input int w, input int h);
      @(posedge clk); #1;
      sel = 1'b1; cfg_width = 16'(w); cfg_height = 16'(h); cfg_bypass = 1'b0; start = 1'b1;
      @(negedge clk);
      chk("rej_cfg_err_pulse", 32'(cfg_err), 1);
      chk("rej_busy_during",   32'(busy), 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("rej_cfg_err_clear", 32'(cfg_err), 0);
      chk("rej_busy_after",    32'(busy), 0);
      chk("rej_s_ready_after", 32'(s_ready), 0);
   endtask

   task automatic run_frame(input bit s5, input int w, input int h, input bit byp,
                            input int vprob, input bit rdy_rand, input int abort_at, input bit chk_lat);
      int k = s5 ? 5 : 3;
      int n_in = w * h;
      int in_idx = 0, out_idx = 0, n_exp, acc_edge = 0;
      bit finished = 0, aborted = 0, stall_prev = 0, hs_in, hs_out;
      logic [7:0] prev_data;
      logic prev_last;
      build_exp(k, w, h, byp);
      n_exp = exp_q.size();
      @(posedge clk); #1;
      sel = s5; cfg_width = 16'(w); cfg_height = 16'(h); cfg_bypass = byp;
      start = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      chk("start_cfg_err", 32'(cfg_err), 0);
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         s_valid = (in_idx < n_in) && ($urandom_range(0, 99) < vprob);
         s_data  = (in_idx < n_in) ? 8'(pix[in_idx]) : 8'd0;
         m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (cyc == 0) chk("busy_run", 32'(busy), 1);
         hs_in  = s_valid && s_ready;
         hs_out = m_valid && m_ready;
         if (m_valid && !m_ready) chk("stall_s_ready", 32'(s_ready), 0);
         if (stall_prev) begin
            chk("hold_valid", 32'(m_valid), 1);
            chk("hold_data",  32'(m_data), 32'(prev_data));
            chk("hold_last",  32'(m_last), 32'(prev_last));
         end
         stall_prev = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         chk("done", 32'(done), 32'(hs_out && (out_idx == n_exp - 1)));
         if (hs_in) begin
            in_idx++;
            acc_edge = cyc + 1;
         end
         if (hs_out && out_idx < n_exp) begin
            chk("data", 32'(m_data), exp_q[out_idx]);
            chk("last", 32'(m_last), 32'(out_idx == n_exp - 1));
            if (chk_lat && out_idx == n_exp - 1) chk("latency", cyc - acc_edge, 3);
            out_idx++;
            if (out_idx == n_exp) finished = 1;
         end
         if (abort_at > 0 && in_idx == abort_at) begin
            finished = 1;
            aborted  = 1;
         end
         if (finished) break;
         @(posedge clk); #1;
      end
      if (!finished) chk("timeout_outputs", out_idx, n_exp);
      @(posedge clk); #1;
      s_valid = 1'b0;
      m_ready = 1'b1;
      if (aborted) begin
         rst = 1'b1;
         @(posedge clk); #1;
         @(negedge clk);
         check_reset_vals("abort");
         @(posedge clk); #1;
         rst = 1'b0;
         @(negedge clk);
         chk("post_reset_busy",    32'(busy), 0);
         chk("post_reset_s_ready", 32'(s_ready), 0);
      end else begin
         @(negedge clk);
         chk("out_count",        out_idx, n_exp);
         chk("busy_after_done",  32'(busy), 0);
         chk("valid_after_done", 32'(m_valid), 0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cfg_bypass = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
      sel = 1'b1; cfg_width = '0; cfg_height = '0; s_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst_k5");
      sel = 1'b0;
      #1;
      check_reset_vals("rst_k3");
      @(posedge clk); #1;
      rst = 1'b0;

      fill_pix(0, 5, 5, 100);  run_frame(1'b1, 5, 5, 1'b0, 100, 1'b0, 0, 1'b1);
      fill_pix(1, 7, 7, 0);    run_frame(1'b0, 7, 7, 1'b0, 100, 1'b0, 0, 1'b0);
      fill_pix(2, 8, 4, 0);    run_frame(1'b0, 8, 4, 1'b0, 70, 1'b1, 0, 1'b0);
      fill_pix(3, 3, 2, 0);    run_frame(1'b1, 3, 2, 1'b1, 100, 1'b0, 0, 1'b0);
      cfg_reject(4, 5);
      cfg_reject(257, 5);
      fill_pix(2, 5, 5, 0);    run_frame(1'b1, 5, 5, 1'b0, 100, 1'b0, 10, 1'b0);
      fill_pix(2, 5, 5, 0);    run_frame(1'b1, 5, 5, 1'b0, 100, 1'b0, 0, 1'b1);
      for (int r = 0; r < 4; r++) begin
         bit s5  = 1'($urandom_range(0, 1));
         bit byp = 1'($urandom_range(0, 3) == 0);
         int kk  = s5 ? 5 : 3;
         int w   = byp ? int'($urandom_range(1, 12)) : int'($urandom_range(kk, 12));
         int h   = byp ? int'($urandom_range(1, 7))  : int'($urandom_range(kk, 7));
         fill_pix(2, w, h, 0);
         run_frame(s5, w, h, byp, int'($urandom_range(50, 100)), 1'b1, 0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gs_filter_stream.md
# gs_filter_stream

Parametrised streaming Gaussian filter: the next-generation filter engine of the image pipeline, replacing fixed-size, RAM-addressed filtering with a valid/ready pixel stream. Frame geometry is set at run time, kernel size (3 or 5) at build time, and an optional bypass mode is provided. Internally it is a separable binomial filter built from on-chip line buffers. It sits between the frame reader and the frame writer, and full-pipeline stalls give it output backpressure.

## Interface
- `DW`, 8: pixel width.
- `MAX_W`, 256: maximum line width, which sets line-buffer depth.
- `K`, 5: kernel size. Only 3 or 5 is legal; any other value fails elaboration.
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: single-cycle pulse that latches cfg_* and begins a frame.
- `cfg_width` in 16: line width W.
- `cfg_height` in 16: frame height H.
- `cfg_bypass` in 1: 1 = pass pixels unfiltered.
- `s_valid` in 1, `s_data` in DW, `s_ready` out 1: input pixel stream, raster order.
- `m_valid` out 1, `m_data` out DW, `m_last` out 1, `m_ready` in 1: output pixel stream. `m_last` marks the final pixel of the frame.
- `busy` out 1: high from accepted start until done.
- `done` out 1: one-cycle pulse on the final output handshake.
- `cfg_err` out 1: one-cycle pulse when a start is rejected.

## Operation
- FSM states are IDLE, RUN, DRAIN.
- IDLE -> RUN on start with a legal configuration:
  - Filter mode: K ≤ W ≤ MAX_W and H ≥ K.
  - Bypass mode: W ≥ 1 and H ≥ 1.
  - Otherwise cfg_err pulses and the FSM stays in IDLE.
- start in RUN or DRAIN is ignored and does not pulse cfg_err.
- RUN -> DRAIN when the W·H-th input pixel is accepted.
- DRAIN -> IDLE on the final output handshake, with done pulsing in the same cycle.
- Input counters x (0..W-1) and y (0..H-1) advance on each s handshake. x wraps to 0 and increments y.
- Filter path:
  - K-1 line buffers, each MAX_W deep and read-before-write at address x.
  - Column sum uses binomial weights: [1 2 1] for K=3, [1 4 6 4 1] for K=5.
  - A K-deep horizontal shift register of column sums feeds the same weighted row sum.
  - Total weight is 2^S, with S = 4 (K=3) or 8 (K=5).
  - Result = (sum + 2^(S-1)) >> S. It always fits DW, so no saturation is needed.
  - Widths are vertical sum DW+S/2 and total DW+S.
- Filter output is valid-region only: an output is produced for input (x,y) only when x ≥ K-1 and y ≥ K-1.
  - Output frame is (W-K+1)×(H-K+1).
  - Output pixel (i,j) is centred on input (i+(K-1)/2, j+(K-1)/2).
- Bypass: every input pixel is output unchanged, giving a W×H frame. Pipeline depth is identical to filter mode.
- m_last is asserted with the output generated from input (W-1,H-1).
- Line buffer contents are never cleared. Stale data is masked by the coordinate gating.

## Timing
- Stage enable `en = !m_valid || m_ready`. All pipeline stages, line-buffer writes and counters advance only when en is high.
- `s_ready = (state==RUN) && en`.
- Latency is 3 enabled cycles: a pixel accepted at edge t yields m_valid at edge t+3 when there is no stall.
  - Stage 1: column sum registered.
  - Stage 2: row sum registered.
  - Stage 3: rounded output registered.
- While `m_valid && !m_ready`, m_data and m_last are held stable.
- In DRAIN the pipeline keeps advancing on en with no input until the last output handshakes.
- done and the return to IDLE coincide with the final output handshake. A start in the cycle after done is accepted.
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, cfg_err=0. State is IDLE and all counters and pipeline valid bits are 0.
- Reset mid-frame aborts the frame with no done pulse. The first cycle after reset deasserts is IDLE.

## Structure
- Package `gs_filter_pkg` holds:
  - State enum.
  - Binomial coefficient constants for K=3 and K=5.
  - Function returning S for a given K.
  - Width localparams (column-sum and total widths).
- Sub-module `gs_line_buf`: one MAX_W×DW synchronous RAM with read-before-write. K-1 instances.
- Top contains the FSM, counters, sum pipeline and handshake logic.

## Test plan
- K=5, W=H=5, all pixels 100, m_ready=1: exactly one output, 100, with m_last=1 and done on the same cycle. The output arrives 3 cycles after the 25th accept.
- K=3, W=H=7, a single 255 at (3,3), all other pixels 0: 25 outputs. Output (2,2)=64, its orthogonal neighbours=32, its diagonal neighbours=16, all others=0.
- K=3, W=8, H=4, random pixels, m_ready random at 50%: 12 outputs match the reference model bit-exactly. Data is stable during stalls, and s_ready is never high while a stall is held.
- cfg_bypass=1, W=3, H=2, pixels 1..6: outputs 1..6 in order, with m_last on 6.
- K=5, start with W=4 (and again with W=MAX_W+1): cfg_err pulses for 1 cycle, state stays IDLE, and busy stays 0.
- rst asserted mid-frame after 10 accepts: all outputs return to reset values with no done pulse. A following legal frame produces correct results.
